alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Command-driven sequencer for the 3-register ALU datapath (regs A/B/C).
//  Buffers host commands in a small FIFO and drives the datapath control
//  pins cycle by cycle. Supports immediate loads, single or repeated ALU
//  operations with write-back, and register reads returned over a
//  valid/ready response channel. Sits between host/testbench logic and the
//  datapath, which is never driven directly once this block is in place.
// PARAMETERS
//  WIDTH    8  datapath width, equal to the datapath WIDTH
//  DEPTH    4  command FIFO entries, power of 2, >=2
//  CNT_W    4  repeat-count width; an op runs cnt+1 times
// PORTS
//  clk          in   1      clock, rising edge
//  rst_n        in   1      synchronous active-low reset
//  cmd_valid    in   1      command offered
//  cmd_ready    out  1      FIFO can accept, equals !full
//  cmd_type     in   2      00 LOAD, 01 EXEC, 10 READ, 11 reserved
//  cmd_dst      in   2      target reg: 0 A, 1 B, 2 C, 3 illegal
//  cmd_op       in   3      ALU opcode (EXEC)
//  cmd_src      in   1      EXEC operands: 0 A,B; 1 imm,C
//  cmd_cin      in   1      carry-in (EXEC)
//  cmd_cnt      in   CNT_W  repeat count minus one (EXEC)
//  cmd_imm      in   WIDTH  immediate (LOAD data / EXEC src=1 operand)
//  rsp_valid    out  1      read data available
//  rsp_ready    in   1      consumer accepts response
//  rsp_data     out  WIDTH  read value
//  dp_data_in   out  WIDTH  datapath data input
//  dp_reg_sel   out  2      datapath register select
//  dp_alu_op    out  3      datapath opcode
//  dp_write_en  out  1      datapath register write strobe
//  dp_alu_en    out  1      datapath ALU-result/operand select
//  dp_cin       out  1      datapath carry-in
//  dp_data_out  in   WIDTH  datapath selected-register output
//  dp_zero, dp_neg, dp_ovf  in  1 each  datapath flags
//  last_zero, last_neg, last_ovf  out  1 each  flags from last EXEC cycle
//  busy         out  1      FSM not IDLE or FIFO not empty
//  cmd_err      out  1      1-cycle pulse: illegal command discarded
// BEHAVIOUR
//  Reset: state IDLE, FIFO empty, rsp_valid=0, rsp_data=0, all dp_*=0,
//   last_*=0, cmd_err=0, busy=0. Reset mid-operation aborts the current
//   repeat, flushes the FIFO, and drops any pending response. Datapath
//   register contents are the datapath's own concern.
//  FIFO: push when cmd_valid&cmd_ready. Pop only in IDLE. Push and pop in
//   the same cycle leave count unchanged. No bypass: a command accepted at
//   edge T is popped no earlier than edge T+1. Pointers wrap mod DEPTH.
//  FSM states: IDLE, LOAD, EXEC, READ, RESP. In IDLE, when the FIFO is not
//   empty, pop the head into the cur register and go to the cmd_type state.
//   Type 11 or dst=3: discard the command, pulse cmd_err, stay IDLE.
//  dp_* outputs are decoded from state and cur only. Outside LOAD/EXEC,
//   dp_write_en=0.
//  LOAD (1 cycle): write_en=1, alu_en=0, reg_sel=dst, data_in=imm.
//   Then IDLE.
//  EXEC: write_en=1, alu_en=src, alu_op=op, reg_sel=dst, data_in=imm,
//   cin=cin. A repeat counter counts iterations 0..cnt, one write per
//   cycle; each iteration sees the prior write-back. Capture dp_zero,
//   dp_neg, dp_ovf into last_* every EXEC cycle. Then IDLE.
//  READ (1 cycle): write_en=0, reg_sel=dst. Register dp_data_out into
//   rsp_data, then go to RESP.
//  RESP: rsp_valid=1 with rsp_data stable. Leave to IDLE on rsp_ready.
//   rsp_valid stays asserted while rsp_ready=0. The FIFO keeps accepting.
//  Latency into an empty, idle block: accepted at edge T, write occurs at
//   edge T+2. For READ, rsp_valid is high from edge T+2.
//  Throughput: LOAD 2 cycles/cmd; EXEC cnt+2 cycles; READ at least 3.
// TESTING (WIDTH=8, DEPTH=4)
//  LOAD A=05, LOAD B=03, EXEC add(000) dst C src0, READ C -> rsp_data=08,
//   last_zero=0.
//  LOAD A=01, B=01, EXEC add dst A cnt=7, READ A -> 09, exactly 8 write
//   strobes.
//  LOAD A=7F, B=01, EXEC add dst C, READ C -> 80, last_ovf=1, last_neg=1.
//  rsp_ready=0, READ then 5 commands -> cmd_ready drops after 4 queued,
//   none lost, order kept.
//  LOAD with dst=3 -> cmd_err pulses once, no write strobe, next command
//   runs normally.
//  rst_n=0 during EXEC cnt=15 -> next cycle write_en=0, cmd_ready=1,
//   rsp_valid=0, busy=0.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Command sequencer for the 3-register ALU datapath: buffers host commands in a
// FIFO and drives datapath control pins, returning register reads over valid/ready.
module alu_op_sequencer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_type,
    input  logic [1:0]       cmd_dst,
    input  logic [2:0]       cmd_op,
    input  logic             cmd_src,
    input  logic             cmd_cin,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic [WIDTH-1:0] cmd_imm,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [WIDTH-1:0] dp_data_in,
    output logic [1:0]       dp_reg_sel,
    output logic [2:0]       dp_alu_op,
    output logic             dp_write_en,
    output logic             dp_alu_en,
    output logic             dp_cin,
    input  logic [WIDTH-1:0] dp_data_out,
    input  logic             dp_zero,
    input  logic             dp_neg,
    input  logic             dp_ovf,
    output logic             last_zero,
    output logic             last_neg,
    output logic             last_ovf,
    output logic             busy,
    output logic             cmd_err
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [1:0]       dst;
        logic [2:0]       op;
        logic             src;
        logic             cin;
        logic [CNT_W-1:0] cnt;
        logic [WIDTH-1:0] imm;
    } body_t;

    typedef struct packed {
        logic [1:0] typ;
        body_t      body;
    } cmd_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EXEC,
        S_READ,
        S_RESP
    } state_t;

    state_t           state_q, state_d;
    body_t            cur_q, cur_d;
    logic [CNT_W-1:0] rep_q, rep_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [2:0]       flags_q, flags_d;
    logic             cmd_err_q, cmd_err_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    cmd_t             mem_q [DEPTH];
    cmd_t             mem_d [DEPTH];
    cmd_t             head;
    logic             push, pop;

    assign cmd_ready = (count_q != (PTR_W+1)'(DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign busy      = (state_q != S_IDLE) || (count_q != '0);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_data  = rsp_data_q;
    assign last_zero = flags_q[0];
    assign last_neg  = flags_q[1];
    assign last_ovf  = flags_q[2];
    assign cmd_err   = cmd_err_q;

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        rep_d      = rep_q;
        rsp_data_d = rsp_data_q;
        flags_d    = flags_q;
        cmd_err_d  = 1'b0;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        pop        = 1'b0;
        head       = mem_q[rd_ptr_q];

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop = 1'b1;
                    // Illegal commands are consumed here so they never reach the datapath
                    if (head.typ == 2'b11 || head.body.dst == 2'b11) begin
                        cmd_err_d = 1'b1;
                    end else begin
                        cur_d = head.body;
                        rep_d = '0;
                        case (head.typ)
                            2'b00:   state_d = S_LOAD;
                            2'b01:   state_d = S_EXEC;
                            default: state_d = S_READ;
                        endcase
                    end
                end
            end
            S_LOAD: state_d = S_IDLE;
            S_EXEC: begin
                flags_d = {dp_ovf, dp_neg, dp_zero};
                if (rep_q == cur_q.cnt) state_d = S_IDLE;
                else                    rep_d = rep_q + CNT_W'(1);
            end
            S_READ: begin
                rsp_data_d = dp_data_out;
                state_d    = S_RESP;
            end
            S_RESP: if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (push) begin
            mem_d[wr_ptr_q] = '{typ: cmd_type,
                                body: '{dst: cmd_dst, op: cmd_op, src: cmd_src,
                                        cin: cmd_cin, cnt: cmd_cnt, imm: cmd_imm}};
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        dp_data_in  = '0;
        dp_reg_sel  = '0;
        dp_alu_op   = '0;
        dp_write_en = 1'b0;
        dp_alu_en   = 1'b0;
        dp_cin      = 1'b0;
        case (state_q)
            S_LOAD: begin
                dp_write_en = 1'b1;
                dp_reg_sel  = cur_q.dst;
                dp_data_in  = cur_q.imm;
            end
            S_EXEC: begin
                dp_write_en = 1'b1;
                dp_alu_en   = cur_q.src;
                dp_alu_op   = cur_q.op;
                dp_reg_sel  = cur_q.dst;
                dp_data_in  = cur_q.imm;
                dp_cin      = cur_q.cin;
            end
            S_READ: dp_reg_sel = cur_q.dst;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cur_q      <= '0;
            rep_q      <= '0;
            rsp_data_q <= '0;
            flags_q    <= '0;
            cmd_err_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            rep_q      <= rep_d;
            rsp_data_q <= rsp_data_d;
            flags_q    <= flags_d;
            cmd_err_q  <= cmd_err_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once count says they are valid
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural 3-register add datapath.
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_type = '0;
    logic [1:0] cmd_dst = '0;
    logic [2:0] cmd_op = '0;
    logic       cmd_src = 1'b0;
    logic       cmd_cin = 1'b0;
    logic [3:0] cmd_cnt = '0;
    logic [7:0] cmd_imm = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic [7:0] dp_data_in;
    logic [1:0] dp_reg_sel;
    logic [2:0] dp_alu_op;
    logic       dp_write_en, dp_alu_en, dp_cin;
    logic [7:0] dp_data_out;
    logic       dp_zero, dp_neg, dp_ovf;
    logic       last_zero, last_neg, last_ovf;
    logic       busy, cmd_err;

    int errors = 0;
    int checks = 0;
    int wr_count = 0;
    int err_pulses = 0;

    alu_op_sequencer #(.WIDTH(8), .DEPTH(4), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
        .cmd_dst(cmd_dst), .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_cin(cmd_cin),
        .cmd_cnt(cmd_cnt), .cmd_imm(cmd_imm),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .dp_data_in(dp_data_in), .dp_reg_sel(dp_reg_sel), .dp_alu_op(dp_alu_op),
        .dp_write_en(dp_write_en), .dp_alu_en(dp_alu_en), .dp_cin(dp_cin),
        .dp_data_out(dp_data_out), .dp_zero(dp_zero), .dp_neg(dp_neg), .dp_ovf(dp_ovf),
        .last_zero(last_zero), .last_neg(last_neg), .last_ovf(last_ovf),
        .busy(busy), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    // Datapath model: the bench knows which write strobes come from LOAD vs EXEC
    logic [7:0] ra = '0, rb = '0, rc = '0;
    logic [7:0] opa, opb, alu_r, wdata;
    logic       alu_ovf, wr_kind;
    bit         kind_q[$];

    always_comb begin
        opa     = dp_alu_en ? dp_data_in : ra;
        opb     = dp_alu_en ? rc : rb;
        alu_ovf = 1'b0;
        if (dp_alu_op == 3'd0) begin
            alu_r   = opa + opb + {7'd0, dp_cin};
            alu_ovf = (opa[7] == opb[7]) && (alu_r[7] != opa[7]);
        end else begin
            alu_r = opa ^ opb;
        end
    end

    assign dp_zero = (alu_r == 8'h00);
    assign dp_neg  = alu_r[7];
    assign dp_ovf  = alu_ovf;
    assign dp_data_out = (dp_reg_sel == 2'd0) ? ra : (dp_reg_sel == 2'd1) ? rb :
                         (dp_reg_sel == 2'd2) ? rc : 8'h00;

    always @(posedge clk) begin
        if (cmd_err) err_pulses++;
        if (dp_write_en) begin
            wr_count++;
            wr_kind = (kind_q.size() > 0) ? kind_q.pop_front() : 1'b0;
            wdata   = wr_kind ? alu_r : dp_data_in;
            case (dp_reg_sel)
                2'd0: ra <= wdata;
                2'd1: rb <= wdata;
                2'd2: rc <= wdata;
                default: ;
            endcase
        end
    end

    task automatic send(input logic [1:0] typ, input logic [1:0] dst, input logic [2:0] op,
                        input logic src, input logic [3:0] cnt, input logic [7:0] imm);
        int n = 0;
        @(negedge clk);
        cmd_type = typ; cmd_dst = dst; cmd_op = op; cmd_src = src;
        cmd_cin = 1'b0; cmd_cnt = cnt; cmd_imm = imm; cmd_valid = 1'b1;
        if (dst != 2'd3 && typ == 2'd0) kind_q.push_back(1'b0);
        if (dst != 2'd3 && typ == 2'd1)
            for (int i = 0; i <= int'(cnt); i++) kind_q.push_back(1'b1);
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            errors++;
            $display("FAIL send_timeout: cmd_ready=%b expected 1", cmd_ready);
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic load(input logic [1:0] dst, input logic [7:0] imm);
        send(2'd0, dst, 3'd0, 1'b0, 4'd0, imm);
    endtask

    task automatic exec_add(input logic [1:0] dst, input logic [3:0] cnt);
        send(2'd1, dst, 3'd0, 1'b0, cnt, 8'h00);
    endtask

    task automatic read(input logic [1:0] dst);
        send(2'd2, dst, 3'd0, 1'b0, 4'd0, 8'h00);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            errors++;
            $display("FAIL %s_idle_timeout: busy=%b expected 0", name, busy);
        end
    endtask

    task automatic get_rsp(input logic [7:0] exp, input string name);
        int n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!rsp_valid) begin
            errors++;
            $display("FAIL %s_rsp_timeout: rsp_valid=%b expected 1", name, rsp_valid);
        end else if (rsp_data !== exp) begin
            errors++;
            $display("FAIL %s: rsp_data=%h expected %h", name, rsp_data, exp);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({dp_write_en, dp_alu_en, dp_cin, dp_reg_sel, dp_alu_op, dp_data_in} !== 16'h0) begin
            errors++;
            $display("FAIL reset_dp: dp=%h expected 0",
                     {dp_write_en, dp_alu_en, dp_cin, dp_reg_sel, dp_alu_op, dp_data_in});
        end
        checks++;
        if ({cmd_ready, busy, rsp_valid, cmd_err} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_ctrl: ready/busy/rvalid/err=%b expected 1000",
                     {cmd_ready, busy, rsp_valid, cmd_err});
        end
        checks++;
        if ({rsp_data, last_zero, last_neg, last_ovf} !== 11'h0) begin
            errors++;
            $display("FAIL reset_data: rsp/flags=%h expected 0",
                     {rsp_data, last_zero, last_neg, last_ovf});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_load_latency;
        load(2'd0, 8'h05);
        checks++;
        if (dp_write_en !== 1'b0) begin
            errors++; $display("FAIL lat_t0: write_en=%b expected 0", dp_write_en);
        end
        @(negedge clk);
        checks++;
        if (dp_write_en !== 1'b0) begin
            errors++; $display("FAIL lat_t1: write_en=%b expected 0", dp_write_en);
        end
        @(negedge clk);
        checks++;
        if (dp_write_en !== 1'b1 || dp_reg_sel !== 2'd0 || dp_data_in !== 8'h05 || dp_alu_en !== 1'b0) begin
            errors++;
            $display("FAIL lat_t2: we/sel/din/alu_en=%b/%0d/%h/%b expected 1/0/05/0",
                     dp_write_en, dp_reg_sel, dp_data_in, dp_alu_en);
        end
        @(negedge clk);
        checks++;
        if (dp_write_en !== 1'b0 || ra !== 8'h05) begin
            errors++;
            $display("FAIL lat_t3: write_en=%b A=%h expected 0 05", dp_write_en, ra);
        end
    endtask

    task automatic test_basic_add;
        load(2'd1, 8'h03);
        exec_add(2'd2, 4'd0);
        read(2'd2);
        get_rsp(8'h08, "add_5_3");
        checks++;
        if (last_zero !== 1'b0) begin
            errors++; $display("FAIL add_last_zero: last_zero=%b expected 0", last_zero);
        end
    endtask

    task automatic test_repeat;
        int w0;
        load(2'd0, 8'h01);
        load(2'd1, 8'h01);
        wait_idle("repeat_pre");
        w0 = wr_count;
        exec_add(2'd0, 4'd7);
        wait_idle("repeat");
        checks++;
        if (wr_count - w0 != 8) begin
            errors++; $display("FAIL repeat_strobes: writes=%0d expected 8", wr_count - w0);
        end
        read(2'd0);
        get_rsp(8'h09, "repeat_result");
    endtask

    task automatic test_overflow;
        load(2'd0, 8'h7F);
        load(2'd1, 8'h01);
        exec_add(2'd2, 4'd0);
        read(2'd2);
        get_rsp(8'h80, "ovf_result");
        checks++;
        if ({last_zero, last_neg, last_ovf} !== 3'b011) begin
            errors++;
            $display("FAIL ovf_flags: zero/neg/ovf=%b expected 011", {last_zero, last_neg, last_ovf});
        end
    endtask

    task automatic test_back_to_back;
        int n = 0;
        read(2'd2);
        @(negedge clk);
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        load(2'd0, 8'h11);
        load(2'd1, 8'h22);
        read(2'd0);
        read(2'd1);
        fork
            load(2'd2, 8'h33);
            begin
                repeat (3) @(negedge clk);
                checks++;
                if (cmd_ready !== 1'b0) begin
                    errors++; $display("FAIL fifo_full: cmd_ready=%b expected 0", cmd_ready);
                end
                checks++;
                if (rsp_valid !== 1'b1 || rsp_data !== 8'h80) begin
                    errors++;
                    $display("FAIL rsp_hold: rsp_valid=%b data=%h expected 1 80", rsp_valid, rsp_data);
                end
                get_rsp(8'h80, "stalled_read");
            end
        join
        get_rsp(8'h11, "order_first");
        get_rsp(8'h22, "order_second");
        read(2'd2);
        get_rsp(8'h33, "fifth_cmd");
    endtask

    task automatic test_illegal;
        int e0, w0;
        wait_idle("illegal_pre");
        e0 = err_pulses;
        w0 = wr_count;
        load(2'd3, 8'hAA);
        wait_idle("illegal");
        repeat (2) @(negedge clk);
        checks++;
        if (err_pulses - e0 != 1) begin
            errors++; $display("FAIL err_pulse: pulses=%0d expected 1", err_pulses - e0);
        end
        checks++;
        if (wr_count != w0) begin
            errors++; $display("FAIL err_no_write: writes=%0d expected 0", wr_count - w0);
        end
        send(2'd3, 2'd1, 3'd0, 1'b0, 4'd0, 8'h55);
        wait_idle("reserved");
        repeat (2) @(negedge clk);
        checks++;
        if (err_pulses - e0 != 2 || wr_count != w0) begin
            errors++;
            $display("FAIL reserved_type: pulses=%0d writes=%0d expected 2 0",
                     err_pulses - e0, wr_count - w0);
        end
        load(2'd1, 8'h44);
        read(2'd1);
        get_rsp(8'h44, "after_err");
    endtask

    task automatic test_reset_mid_exec;
        int n = 0;
        load(2'd0, 8'h00);
        load(2'd1, 8'h01);
        exec_add(2'd0, 4'd15);
        read(2'd0);
        while (!dp_write_en && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({dp_write_en, cmd_ready, rsp_valid, busy} !== 4'b0100) begin
            errors++;
            $display("FAIL mid_reset: we/ready/rvalid/busy=%b expected 0100",
                     {dp_write_en, cmd_ready, rsp_valid, busy});
        end
        rst_n = 1'b1;
        kind_q.delete();
        repeat (5) @(negedge clk);
        checks++;
        if (dp_write_en !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL flushed: write_en=%b busy=%b expected 0 0", dp_write_en, busy);
        end
        load(2'd2, 8'h5A);
        read(2'd2);
        get_rsp(8'h5A, "post_reset");
    endtask

    initial begin
        test_reset();
        test_load_latency();
        test_basic_add();
        test_repeat();
        test_overflow();
        test_back_to_back();
        test_illegal();
        test_reset_mid_exec();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
